// File: rtl/display_scan_mux_if.sv
// Bus between the scan controller and its host: value load side plus the
// digit/anode drive toward the 7-segment decoder.
interface display_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    blank_lz;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    update_ack;

  modport master (output value_in, load, blank_lz, input digit, anode, update_ack);
  modport slave  (input value_in, load, blank_lz, output digit, anode, update_ack);
endinterface

// File: rtl/display_scan_mux.sv
// Multiplexed 7-segment scan controller: one digit per slot, new values
// committed only at frame boundaries, optional leading-zero blanking.
module display_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  display_scan_mux_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4*NUM_DIGITS;

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] active_q, active_d;
  logic [VW-1:0] pending_q, pending_d;
  logic          pend_v_q, pend_v_d;
  logic          ack_q, ack_d;
  logic          tick, frame_end;

  always_comb begin
    tick      = (presc_q == PW'(REFRESH_DIV-1));
    frame_end = tick && (idx_q == IW'(NUM_DIGITS-1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + 1'b1;

    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    ack_d     = 1'b0;
    // A load on the frame boundary bypasses pending and wins over any older capture.
    if (frame_end) begin
      if (bus.load) begin
        active_d  = bus.value_in;
        pending_d = bus.value_in;
        pend_v_d  = 1'b0;
        ack_d     = 1'b1;
      end else if (pend_v_q) begin
        active_d = pending_q;
        pend_v_d = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (bus.load) begin
      pending_d = bus.value_in;
      pend_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      ack_q     <= ack_d;
    end
  end

  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      zero_up;
  logic                       acc;

  // zero_up[i]: every nibble at index >= i is zero.
  always_comb begin
    nib     = active_q;
    zero_up = '0;
    acc     = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      acc        = acc & (nib[i] == 4'h0);
      zero_up[i] = acc;
    end
  end

  assign bus.anode      = ~(NUM_DIGITS'(1) << idx_q);
  assign bus.digit      = (bus.blank_lz && idx_q != '0 && zero_up[idx_q]) ? 4'hF : nib[idx_q];
  assign bus.update_ack = ack_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed plus randomized checks of display_scan_mux against a time-based
// reference model (slot and frame position derived from the cycle count).
module tb_display_scan_mux;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FL = ND*RD;

  logic clk, rst;
  display_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  int          m_cyc;
  logic [15:0] m_active, m_pending;
  logic        m_pv, m_ack;

  task automatic model_reset();
    m_cyc = 0; m_active = '0; m_pending = '0; m_pv = 1'b0; m_ack = 1'b0;
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_tick();
    bit fe;
    fe    = (m_cyc % FL) == FL-1;
    m_ack = 1'b0;
    if (fe) begin
      if (bus.load) begin
        m_active = bus.value_in; m_pv = 1'b0; m_ack = 1'b1;
      end else if (m_pv) begin
        m_active = m_pending; m_pv = 1'b0; m_ack = 1'b1;
      end
    end else if (bus.load) begin
      m_pending = bus.value_in; m_pv = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic check_all(input string tag);
    int          slot;
    logic [15:0] up;
    logic [3:0]  e_dig;
    logic [3:0]  e_an;
    slot  = (m_cyc / RD) % ND;
    up    = m_active >> (4*slot);
    e_dig = (bus.blank_lz && slot > 0 && up == 16'h0) ? 4'hF : up[3:0];
    e_an  = ~(4'b0001 << slot);
    checks++;
    assert (bus.anode === e_an) else begin
      errors++; $error("FAIL %s anode got %b want %b cyc %0d", tag, bus.anode, e_an, m_cyc);
    end
    checks++;
    assert (bus.digit === e_dig) else begin
      errors++; $error("FAIL %s digit got %h want %h cyc %0d", tag, bus.digit, e_dig, m_cyc);
    end
    checks++;
    assert (bus.update_ack === m_ack) else begin
      errors++; $error("FAIL %s ack got %b want %b cyc %0d", tag, bus.update_ack, m_ack, m_cyc);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input string tag);
    bus.load = ld; bus.value_in = v;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    bus.load = 1'b0;
    check_all(tag);
  endtask

  task automatic idle_to(input int off, input string tag);
    while ((m_cyc % FL) != off) step(1'b0, 16'h0, tag);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert (bus.anode === 4'b1110) else begin
      errors++; $error("FAIL %s anode got %b want 1110", tag, bus.anode);
    end
    checks++;
    assert (bus.digit === 4'h0) else begin
      errors++; $error("FAIL %s digit got %h want 0", tag, bus.digit);
    end
    checks++;
    assert (bus.update_ack === 1'b0) else begin
      errors++; $error("FAIL %s ack got %b want 0", tag, bus.update_ack);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.value_in = '0; bus.blank_lz = 1'b0;
    model_reset();
    #1 check_reset_state("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) step(1'b0, 16'h0, "freerun");

    idle_to(5, "pre_load");
    step(1'b1, 16'h1234, "load_mid");
    for (int i = 0; i < 2*FL; i++) step(1'b0, 16'h0, "show_1234");

    idle_to(2, "pre_two");
    step(1'b1, 16'h1111, "two_a");
    idle_to(9, "two_mid");
    step(1'b1, 16'h2222, "two_b");
    for (int i = 0; i < 2*FL; i++) step(1'b0, 16'h0, "show_2222");

    idle_to(FL-1, "pre_fe");
    step(1'b1, 16'h5678, "load_fe");
    for (int i = 0; i < 2*FL; i++) step(1'b0, 16'h0, "show_5678");

    idle_to(4, "pre_lz");
    bus.blank_lz = 1'b1;
    step(1'b1, 16'h0040, "lz_load");
    for (int i = 0; i < FL+12; i++) step(1'b0, 16'h0, "lz_on");
    bus.blank_lz = 1'b0;
    for (int i = 0; i < FL; i++) step(1'b0, 16'h0, "lz_off");
    bus.blank_lz = 1'b1;
    step(1'b1, 16'h0000, "lz_zero_load");
    for (int i = 0; i < 2*FL; i++) step(1'b0, 16'h0, "lz_zero");

    // Randomized loads (including non-BCD nibbles) with live blank_lz toggling.
    for (int i = 0; i < 300; i++) begin
      bus.blank_lz = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 7) == 0), 16'($urandom), "rand");
      #1 bus.blank_lz = ~bus.blank_lz;
      #1 check_all("rand_live");
    end

    // Reset during slot 2 with a load still pending.
    bus.blank_lz = 1'b0;
    idle_to(FL-1, "pre_rst");
    step(1'b0, 16'h0, "pre_rst");
    idle_to(3, "pre_rst2");
    step(1'b1, 16'h9876, "rst_pend_load");
    idle_to(9, "slot2");
    #2 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3*FL; i++) step(1'b0, 16'h0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Holds a packed multi-digit BCD value and cycles through the digits at a programmable refresh rate. Each cycle it presents one 4-bit digit code to the downstream 7-segment decoder and drives the matching active-low anode enable. New values are applied only at frame boundaries, so the display never tears, and leading-zero blanking is optional.

## Interface
- NUM_DIGITS, 4: number of display digits, 2..8.
- REFRESH_DIV, 50000: clocks per digit slot, at least 2. Prescaler width is $clog2(REFRESH_DIV).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- value_in  input  4*NUM_DIGITS  packed BCD value; nibble i is digit i, digit 0 is least significant.
- load  input  1  single-cycle strobe that captures value_in.
- blank_lz  input  1  when high, leading zeros are blanked. Sampled live.
- digit  output  4  digit code for the downstream decoder; 4'hF means blank.
- anode  output  NUM_DIGITS  active-low digit enables; exactly one bit is low at all times.
- update_ack  output  1  one-cycle pulse when a captured value becomes the displayed value.

## Operation
- Registers:
  - presc: prescaler count.
  - idx: scan index, 0..NUM_DIGITS-1.
  - active: displayed value, 4*NUM_DIGITS bits.
  - pending and pend_v: captured value and its valid flag.
  - update_ack register.
- Prescaler: presc counts 0..REFRESH_DIV-1 and wraps to 0. tick = (presc == REFRESH_DIV-1).
- Scan: on tick, idx increments, wrapping from NUM_DIGITS-1 to 0. frame_end = tick && idx == NUM_DIGITS-1.
- Load capture: on load, pending <= value_in and pend_v <= 1. A later load before frame_end overwrites pending; last load wins.
- Frame commit: on frame_end, if pend_v then active <= pending, pend_v <= 0, update_ack <= 1. Otherwise active is unchanged.
- Load coinciding with frame_end:
  - value_in goes straight to active and update_ack pulses.
  - pend_v clears.
  - Any older pending value is discarded.
- update_ack is 0 in every cycle without a commit.
- Output decode, combinational from registers only, with no input-to-output paths except blank_lz:
  - anode: ~(1 << idx).
  - digit: active[4*idx +: 4], unless blanked.
  - A nibble value above 9 passes through unchanged; the decoder renders it blank.
- Leading-zero blanking: when blank_lz = 1, digit i is blanked (4'hF) iff i > 0 and every nibble of active at index >= i is 0. Digit 0 is never blanked.

## Timing
- Reset values:
  - presc = 0, idx = 0, active = 0, pend_v = 0, pending = 0, update_ack = 0.
  - anode = all ones except bit 0 low; digit = 4'h0.
- Reset asserted mid-frame or with a pending load returns everything to the reset values immediately. The pending value is lost.
- Slot length is exactly REFRESH_DIV clocks. Frame length is NUM_DIGITS*REFRESH_DIV clocks.
- idx, anode and digit change together, in the cycle after the tick edge.
- Load-to-display latency: from 1 clock (load on frame_end) up to NUM_DIGITS*REFRESH_DIV clocks.
- The new value's first visible slot is always idx 0.
- update_ack is high in the first cycle in which the new active value is visible.
- blank_lz changes affect digit combinationally in the same cycle. No re-synchronisation.

## Test plan
Bench parameters: NUM_DIGITS = 4, REFRESH_DIV = 4.
- Reset, then free-run 32 clocks:
  - anode sequence 1110, 1101, 1011, 0111, each held 4 clocks, then repeats.
  - digit = 0 throughout; update_ack never pulses.
- load with value_in = 16'h1234 at clk 5 (mid-frame):
  - digit stays 0 until frame_end at clk 15.
  - update_ack pulses at clk 16.
  - Then digit sequence is 4, 3, 2, 1 per slot.
- Two loads, 16'h1111 then 16'h2222, in one frame:
  - Only 2222 is ever displayed.
  - Exactly one update_ack pulse.
- load 16'h5678 asserted on the frame_end cycle:
  - 5678 is displayed from the next cycle; update_ack pulses there.
  - pend_v = 0; no second ack at the following frame.
- Leading-zero blanking with active = 16'h0040:
  - blank_lz = 1 gives digit sequence 0, 4, F, F.
  - blank_lz = 0 gives 0, 4, 0, 0.
  - active = 0 with blank_lz = 1 gives 0, F, F, F.
- Assert rst during slot 2 with a pending load:
  - anode immediately returns to 1110, digit to 0.
  - After release, the pending value never appears and no update_ack is seen.
